// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler
// Picks at most one ready reservation-station row per functional unit each
// cycle, using an independent round-robin pointer per FU. Tells the RS which
// rows were taken (grant_mask, combinational) and hands the chosen row
// indices to the FU issue pipeline one cycle later. Also tracks occupancy of
// the non-pipelined multiplier and honours per-FU stalls and flushes.
module rs_issue_scheduler #(
  parameter int RS_SIZE  = 16,
  parameter int NUM_FU   = 4,
  parameter int MULT_LAT = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [RS_SIZE-1:0]                   entry_valid,
  input  logic [RS_SIZE-1:0]                   entry_ready,
  input  logic [2*RS_SIZE-1:0]                 entry_fu,
  input  logic [NUM_FU-1:0]                    fu_stall,
  output logic [RS_SIZE-1:0]                   grant_mask,
  output logic [NUM_FU-1:0]                    issue_valid,
  output logic [NUM_FU*$clog2(RS_SIZE)-1:0]    issue_idx,
  output logic                                 mult_busy
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  // Fixed FU port encoding shared with the decode stage
  localparam int FU_ALU  = 0;
  localparam int FU_MULT = 1;
  localparam int FU_MEM  = 2;
  localparam int FU_BR   = 3;

  logic [RS_SIZE-1:0] req [NUM_FU];
  logic [NUM_FU-1:0]  fu_eligible;
  logic [NUM_FU-1:0]  granted;
  logic [IDX_W-1:0]   grant_idx [NUM_FU];
  logic [IDX_W-1:0]   rr_ptr [NUM_FU];
  logic [CNT_W-1:0]   mult_cnt;

  // Split the RS rows into one request vector per FU; invalid rows never request
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        req[f][i] = entry_valid[i] & entry_ready[i] & (entry_fu[2*i +: 2] == 2'(f));
      end
    end
  end

  // An FU may take work only when not stalled, not flushing, not in reset, and
  // for the multiplier only once the previous multiply has drained
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      fu_eligible[f] = !fu_stall[f] && !flush && !reset;
    end
    fu_eligible[FU_MULT] = !fu_stall[FU_MULT] && !flush && !reset && (mult_cnt == '0);
  end

  // Round-robin search: first requesting row at or above rr_ptr, wrapping at the top
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand       = '0;
    granted    = '0;
    grant_mask = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      grant_idx[f] = '0;
      for (int k = 0; k < RS_SIZE; k++) begin
        cand = rr_ptr[f] + IDX_W'(k);
        if (fu_eligible[f] && !granted[f] && req[f][cand]) begin
          granted[f]   = 1'b1;
          grant_idx[f] = cand;
        end
      end
      if (granted[f]) begin
        grant_mask[grant_idx[f]] = 1'b1;
      end
    end
  end

  // Issue registers and round-robin pointers; flush squashes issue and rewinds pointers
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid <= '0;
      issue_idx   <= '0;
      for (int f = 0; f < NUM_FU; f++) begin
        rr_ptr[f] <= '0;
      end
    end else if (flush) begin
      issue_valid <= '0;
      for (int f = 0; f < NUM_FU; f++) begin
        rr_ptr[f] <= '0;
      end
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        issue_valid[f] <= granted[f];
        if (granted[f]) begin
          issue_idx[f*IDX_W +: IDX_W] <= grant_idx[f];
          rr_ptr[f]                   <= grant_idx[f] + IDX_W'(1);
        end
      end
    end
  end

  // Multiplier occupancy: load on a grant, otherwise count down to zero (stall does not pause it)
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      mult_cnt <= '0;
    end else if (granted[FU_MULT]) begin
      mult_cnt <= CNT_W'(MULT_LAT - 1);
    end else if (mult_cnt != '0) begin
      mult_cnt <= mult_cnt - CNT_W'(1);
    end
  end

  assign mult_busy = (mult_cnt != '0);

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler
// Directed scenarios for the RS issue scheduler with hand-computed expected
// grants, issue indices and multiplier occupancy.
module tb_rs_issue_scheduler;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [15:0] entry_valid;
  logic [15:0] entry_ready;
  logic [31:0] entry_fu;
  logic [3:0]  fu_stall;
  logic [15:0] grant_mask;
  logic [3:0]  issue_valid;
  logic [15:0] issue_idx;
  logic        mult_busy;

  int total = 0;
  int bad   = 0;

  rs_issue_scheduler #(.RS_SIZE(16), .NUM_FU(4), .MULT_LAT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .entry_valid (entry_valid),
    .entry_ready (entry_ready),
    .entry_fu    (entry_fu),
    .fu_stall    (fu_stall),
    .grant_mask  (grant_mask),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .mult_busy   (mult_busy)
  );

  // Free-running clock, rising edge at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs();
    flush       = 1'b0;
    entry_valid = '0;
    entry_ready = '0;
    entry_fu    = '0;
    fu_stall    = '0;
  endtask

  task automatic set_row(input int row, input logic [1:0] fu);
    entry_valid[row]      = 1'b1;
    entry_ready[row]      = 1'b1;
    entry_fu[2*row +: 2]  = fu;
  endtask

  task automatic drop_row(input int row);
    entry_valid[row] = 1'b0;
    entry_ready[row] = 1'b0;
  endtask

  // Advance one clock and land 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    set_row(3, 2'd0);
    #1;
    total++; if (grant_mask !== 16'h0000) begin bad++; $display("[TB] FAIL reset_grant: got %h want %h", grant_mask, 16'h0000); end
    tick();
    total++; if (issue_valid !== 4'b0000) begin bad++; $display("[TB] FAIL reset_valid: got %b want %b", issue_valid, 4'b0000); end
    total++; if (issue_idx !== 16'h0000) begin bad++; $display("[TB] FAIL reset_idx: got %h want %h", issue_idx, 16'h0000); end
    total++; if (mult_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want %b", mult_busy, 1'b0); end
    reset = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    clear_inputs();
    set_row(3, 2'd0);
    set_row(7, 2'd0);
    #1;
    total++; if (grant_mask !== 16'h0008) begin bad++; $display("[TB] FAIL rr_first_grant: got %h want %h", grant_mask, 16'h0008); end
    tick();
    total++; if (issue_valid !== 4'b0001) begin bad++; $display("[TB] FAIL rr_first_valid: got %b want %b", issue_valid, 4'b0001); end
    total++; if (issue_idx[3:0] !== 4'd3) begin bad++; $display("[TB] FAIL rr_first_idx: got %0d want %0d", issue_idx[3:0], 3); end
    // Row 3 still requests, but the pointer has moved to 4 so row 7 wins
    #1;
    total++; if (grant_mask !== 16'h0080) begin bad++; $display("[TB] FAIL rr_second_grant: got %h want %h", grant_mask, 16'h0080); end
    tick();
    total++; if (issue_idx[3:0] !== 4'd7) begin bad++; $display("[TB] FAIL rr_second_idx: got %0d want %0d", issue_idx[3:0], 7); end
    clear_inputs();
    #1;
    total++; if (grant_mask !== 16'h0000) begin bad++; $display("[TB] FAIL idle_grant: got %h want %h", grant_mask, 16'h0000); end
    tick();
    total++; if (issue_valid !== 4'b0000) begin bad++; $display("[TB] FAIL idle_valid: got %b want %b", issue_valid, 4'b0000); end
  endtask

  // ALU pointer is 8 here; grant row 13 to move it to 14, then exercise the wrap
  task automatic test_wrap();
    clear_inputs();
    set_row(13, 2'd0);
    #1;
    total++; if (grant_mask !== 16'h2000) begin bad++; $display("[TB] FAIL wrap_setup_grant: got %h want %h", grant_mask, 16'h2000); end
    tick();
    clear_inputs();
    set_row(1, 2'd0);
    set_row(15, 2'd0);
    #1;
    total++; if (grant_mask !== 16'h8000) begin bad++; $display("[TB] FAIL wrap_top_grant: got %h want %h", grant_mask, 16'h8000); end
    tick();
    total++; if (issue_idx[3:0] !== 4'd15) begin bad++; $display("[TB] FAIL wrap_top_idx: got %0d want %0d", issue_idx[3:0], 15); end
    #1;
    total++; if (grant_mask !== 16'h0002) begin bad++; $display("[TB] FAIL wrap_low_grant: got %h want %h", grant_mask, 16'h0002); end
    tick();
    total++; if (issue_idx[3:0] !== 4'd1) begin bad++; $display("[TB] FAIL wrap_low_idx: got %0d want %0d", issue_idx[3:0], 1); end
    clear_inputs();
    tick();
  endtask

  task automatic test_mult();
    clear_inputs();
    set_row(2, 2'd1);
    set_row(5, 2'd1);
    #1;
    total++; if (grant_mask !== 16'h0004) begin bad++; $display("[TB] FAIL mult_t0_grant: got %h want %h", grant_mask, 16'h0004); end
    total++; if (mult_busy !== 1'b0) begin bad++; $display("[TB] FAIL mult_t0_busy: got %b want %b", mult_busy, 1'b0); end
    tick();
    total++; if (issue_valid !== 4'b0010) begin bad++; $display("[TB] FAIL mult_t1_valid: got %b want %b", issue_valid, 4'b0010); end
    total++; if (issue_idx[7:4] !== 4'd2) begin bad++; $display("[TB] FAIL mult_t1_idx: got %0d want %0d", issue_idx[7:4], 2); end
    drop_row(2);
    for (int t = 1; t <= 3; t++) begin
      #1;
      total++; if (mult_busy !== 1'b1) begin bad++; $display("[TB] FAIL mult_busy_t%0d: got %b want %b", t, mult_busy, 1'b1); end
      total++; if (grant_mask !== 16'h0000) begin bad++; $display("[TB] FAIL mult_blocked_t%0d: got %h want %h", t, grant_mask, 16'h0000); end
      tick();
    end
    total++; if (mult_busy !== 1'b0) begin bad++; $display("[TB] FAIL mult_t4_busy: got %b want %b", mult_busy, 1'b0); end
    total++; if (grant_mask !== 16'h0020) begin bad++; $display("[TB] FAIL mult_t4_grant: got %h want %h", grant_mask, 16'h0020); end
    tick();
    total++; if (issue_idx[7:4] !== 4'd5) begin bad++; $display("[TB] FAIL mult_t5_idx: got %0d want %0d", issue_idx[7:4], 5); end
    total++; if (mult_busy !== 1'b1) begin bad++; $display("[TB] FAIL mult_t5_busy: got %b want %b", mult_busy, 1'b1); end
    clear_inputs();
    repeat (3) tick();
    total++; if (mult_busy !== 1'b0) begin bad++; $display("[TB] FAIL mult_drain: got %b want %b", mult_busy, 1'b0); end
  endtask

  task automatic test_parallel();
    clear_inputs();
    set_row(0, 2'd0);
    set_row(1, 2'd2);
    set_row(2, 2'd3);
    // Ready but not valid: must be ignored
    entry_ready[9]  = 1'b1;
    entry_fu[19:18] = 2'd0;
    fu_stall = 4'b0100;
    #1;
    total++; if (grant_mask !== 16'h0005) begin bad++; $display("[TB] FAIL par_grant: got %h want %h", grant_mask, 16'h0005); end
    tick();
    total++; if (issue_valid !== 4'b1001) begin bad++; $display("[TB] FAIL par_valid: got %b want %b", issue_valid, 4'b1001); end
    total++; if (issue_idx[15:12] !== 4'd2) begin bad++; $display("[TB] FAIL par_br_idx: got %0d want %0d", issue_idx[15:12], 2); end
    total++; if (issue_idx[3:0] !== 4'd0) begin bad++; $display("[TB] FAIL par_alu_idx: got %0d want %0d", issue_idx[3:0], 0); end
    drop_row(0);
    drop_row(2);
    fu_stall = 4'b0000;
    #1;
    total++; if (grant_mask !== 16'h0002) begin bad++; $display("[TB] FAIL par_mem_grant: got %h want %h", grant_mask, 16'h0002); end
    tick();
    total++; if (issue_valid !== 4'b0100) begin bad++; $display("[TB] FAIL par_mem_valid: got %b want %b", issue_valid, 4'b0100); end
    total++; if (issue_idx[11:8] !== 4'd1) begin bad++; $display("[TB] FAIL par_mem_idx: got %0d want %0d", issue_idx[11:8], 1); end
    clear_inputs();
    tick();
  endtask

  // ALU pointer is 1 and MULT pointer 6 on entry
  task automatic test_flush();
    clear_inputs();
    set_row(6, 2'd1);
    tick();
    clear_inputs();
    tick();
    set_row(4, 2'd0);
    flush = 1'b1;
    #1;
    total++; if (grant_mask !== 16'h0000) begin bad++; $display("[TB] FAIL flush_grant: got %h want %h", grant_mask, 16'h0000); end
    tick();
    total++; if (issue_valid !== 4'b0000) begin bad++; $display("[TB] FAIL flush_valid: got %b want %b", issue_valid, 4'b0000); end
    total++; if (mult_busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy: got %b want %b", mult_busy, 1'b0); end
    // Pointers back at 0: ALU picks row 0 over 4, MULT picks row 1 over 8
    clear_inputs();
    set_row(0, 2'd0);
    set_row(4, 2'd0);
    set_row(1, 2'd1);
    set_row(8, 2'd1);
    #1;
    total++; if (grant_mask !== 16'h0003) begin bad++; $display("[TB] FAIL flush_ptr_grant: got %h want %h", grant_mask, 16'h0003); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    int waited;
    clear_inputs();
    waited = 0;
    while (mult_busy === 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    total++; if (mult_busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_drain_timeout: got %b want %b", mult_busy, 1'b0); end
    set_row(3, 2'd0);
    set_row(4, 2'd1);
    set_row(5, 2'd3);
    tick();
    total++; if (issue_valid !== 4'b1011) begin bad++; $display("[TB] FAIL midreset_pre_valid: got %b want %b", issue_valid, 4'b1011); end
    total++; if (mult_busy !== 1'b1) begin bad++; $display("[TB] FAIL midreset_pre_busy: got %b want %b", mult_busy, 1'b1); end
    clear_inputs();
    set_row(9, 2'd0);
    reset = 1'b1;
    #1;
    total++; if (grant_mask !== 16'h0000) begin bad++; $display("[TB] FAIL midreset_grant: got %h want %h", grant_mask, 16'h0000); end
    tick();
    total++; if (issue_valid !== 4'b0000) begin bad++; $display("[TB] FAIL midreset_valid: got %b want %b", issue_valid, 4'b0000); end
    total++; if (issue_idx !== 16'h0000) begin bad++; $display("[TB] FAIL midreset_idx: got %h want %h", issue_idx, 16'h0000); end
    total++; if (mult_busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b want %b", mult_busy, 1'b0); end
    reset = 1'b0;
    clear_inputs();
    // ALU pointer was 4 before reset; row 0 must win over row 12 now
    set_row(0, 2'd0);
    set_row(12, 2'd0);
    #1;
    total++; if (grant_mask !== 16'h0001) begin bad++; $display("[TB] FAIL midreset_ptr_grant: got %h want %h", grant_mask, 16'h0001); end
    tick();
    clear_inputs();
    tick();
  endtask

  // Multiplier counter keeps draining while MULT is stalled
  task automatic test_mult_stall();
    clear_inputs();
    set_row(10, 2'd1);
    #1;
    total++; if (grant_mask !== 16'h0400) begin bad++; $display("[TB] FAIL mstall_grant: got %h want %h", grant_mask, 16'h0400); end
    tick();
    clear_inputs();
    fu_stall = 4'b0010;
    set_row(11, 2'd1);
    repeat (3) tick();
    total++; if (mult_busy !== 1'b0) begin bad++; $display("[TB] FAIL mstall_busy: got %b want %b", mult_busy, 1'b0); end
    total++; if (grant_mask !== 16'h0000) begin bad++; $display("[TB] FAIL mstall_held_grant: got %h want %h", grant_mask, 16'h0000); end
    fu_stall = 4'b0000;
    #1;
    total++; if (grant_mask !== 16'h0800) begin bad++; $display("[TB] FAIL mstall_release_grant: got %h want %h", grant_mask, 16'h0800); end
    tick();
    total++; if (issue_valid !== 4'b0010) begin bad++; $display("[TB] FAIL mstall_release_valid: got %b want %b", issue_valid, 4'b0010); end
    clear_inputs();
    tick();
  endtask

  // Scenario sequence
  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) tick();
    $display("[TB] starting directed scenarios");
    test_reset();
    test_round_robin();
    test_wrap();
    test_mult();
    test_parallel();
    test_flush();
    test_reset_mid();
    test_mult_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
